// File: rtl/pc_unit.sv
// pc_unit: program-counter register and next-PC selection for the head of IF.
// Handles stall hold, exception entry, ERET return, a one-entry buffer that
// remembers a redirect raised while stalled, and flags misaligned PCs.
module pc_unit #(
  parameter int unsigned       WIDTH         = 32,
  parameter logic [WIDTH-1:0]  RESET_PC      = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR    = 32'h0000_4180,
  parameter bit                HOLD_REDIRECT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       npc_sel,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] j_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] npc,
  output logic             redirect_pending,
  output logic             pc_misaligned
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] sel_target;
  logic [WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_STEP;

  // Target mux driven directly by npc_sel.
  always_comb begin
    sel_target = pc_plus4;
    unique case (npc_sel)
      2'b00:   sel_target = pc_plus4;
      2'b01:   sel_target = br_target;
      2'b10:   sel_target = jr_target;
      2'b11:   sel_target = j_target;
      default: sel_target = pc_plus4;
    endcase
  end

  // Next-PC priority: exception, ERET, stall hold, buffered replay, normal select.
  // Exception and ERET both abandon any buffered redirect since control flow
  // has moved elsewhere.
  always_comb begin
    pc_d   = sel_target;
    buf_d  = buf_q;
    pend_d = pend_q;
    if (exc_req) begin
      pc_d   = EXC_VECTOR;
      pend_d = 1'b0;
    end else if (eret) begin
      pc_d   = epc;
      pend_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
      if (HOLD_REDIRECT && (npc_sel != 2'b00)) begin
        buf_d  = sel_target;
        pend_d = 1'b1;
      end
    end else if (pend_q) begin
      pc_d   = buf_q;
      pend_d = 1'b0;
    end
  end

  // State update; reset wins over everything, including a buffered redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      buf_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      buf_q  <= buf_d;
      pend_q <= pend_d;
    end
  end

  assign pc               = pc_q;
  assign pc4              = pc_plus4;
  assign npc              = pc_d;
  assign redirect_pending = pend_q;
  assign pc_misaligned    = |pc_q[1:0];

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; a second instance with HOLD_REDIRECT = 0 shares
// the stimulus so redirect dropping during stall is also exercised.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, exc_req, eret;
  logic [1:0]  npc_sel;
  logic [31:0] br_target, jr_target, j_target, epc;

  logic [31:0] pc, pc4, npc;
  logic        redirect_pending, pc_misaligned;
  logic [31:0] pc_n, pc4_n, npc_n;
  logic        rp_n, mis_n;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .br_target(br_target), .jr_target(jr_target), .j_target(j_target),
    .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc4(pc4), .npc(npc),
    .redirect_pending(redirect_pending), .pc_misaligned(pc_misaligned)
  );

  pc_unit #(.HOLD_REDIRECT(1'b0)) dut_nohold (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .br_target(br_target), .jr_target(jr_target), .j_target(j_target),
    .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc_n), .pc4(pc4_n), .npc(npc_n),
    .redirect_pending(rp_n), .pc_misaligned(mis_n)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; stall = 1'b0; npc_sel = 2'b00; exc_req = 1'b0; eret = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; exc_req = 1'b0; eret = 1'b0;
    npc_sel = 2'b01; br_target = 32'h100;
    jr_target = 32'h0; j_target = 32'h0; epc = 32'h0;
    tick();
    tests_run++;
    if (pc !== 32'h3000) begin
      tests_failed++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000);
    end
    tests_run++;
    if (redirect_pending !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pending: got %b want 0", redirect_pending);
    end
    reset = 1'b0; npc_sel = 2'b00;
    tick();
    tests_run++;
    if (pc !== 32'h3004) begin
      tests_failed++; $display("FAIL reset_seq1: got %h want %h", pc, 32'h3004);
    end
    tick();
    tests_run++;
    if (pc !== 32'h3008) begin
      tests_failed++; $display("FAIL reset_seq2: got %h want %h", pc, 32'h3008);
    end
    tick();
    tests_run++;
    if (pc !== 32'h300C) begin
      tests_failed++; $display("FAIL reset_seq3: got %h want %h", pc, 32'h300C);
    end
    tests_run++;
    if (pc4 !== 32'h3010 || npc !== 32'h3010) begin
      tests_failed++; $display("FAIL reset_pc4_npc: got pc4 %h npc %h want 3010", pc4, npc);
    end
  endtask

  task automatic test_select;
    do_reset();
    npc_sel = 2'b01; br_target = 32'h3040;
    #1;
    tests_run++;
    if (npc !== 32'h3040) begin
      tests_failed++; $display("FAIL sel_npc_br: got %h want %h", npc, 32'h3040);
    end
    tick();
    tests_run++;
    if (pc !== 32'h3040) begin
      tests_failed++; $display("FAIL sel_br: got %h want %h", pc, 32'h3040);
    end
    npc_sel = 2'b10; jr_target = 32'h5000;
    tick();
    tests_run++;
    if (pc !== 32'h5000) begin
      tests_failed++; $display("FAIL sel_jr: got %h want %h", pc, 32'h5000);
    end
    npc_sel = 2'b11; j_target = 32'h3100;
    tick();
    tests_run++;
    if (pc !== 32'h3100 || pc_misaligned !== 1'b0) begin
      tests_failed++; $display("FAIL sel_j: got %h mis %b want 3100 mis 0", pc, pc_misaligned);
    end
    npc_sel = 2'b00;
  endtask

  task automatic test_stall_replay;
    do_reset();
    npc_sel = 2'b00;
    repeat (4) tick();
    tests_run++;
    if (pc !== 32'h3010) begin
      tests_failed++; $display("FAIL stall_setup: got %h want %h", pc, 32'h3010);
    end
    stall = 1'b1; npc_sel = 2'b01; br_target = 32'h3080;
    #1;
    tests_run++;
    if (npc !== 32'h3010) begin
      tests_failed++; $display("FAIL stall_npc_hold: got %h want %h", npc, 32'h3010);
    end
    tick();
    tests_run++;
    if (pc !== 32'h3010 || redirect_pending !== 1'b1) begin
      tests_failed++; $display("FAIL stall_c1: got pc %h rp %b want 3010 rp 1", pc, redirect_pending);
    end
    tests_run++;
    if (rp_n !== 1'b0 || pc_n !== 32'h3010) begin
      tests_failed++; $display("FAIL nohold_c1: got pc %h rp %b want 3010 rp 0", pc_n, rp_n);
    end
    npc_sel = 2'b10; jr_target = 32'h3200;
    tick();
    npc_sel = 2'b00;
    tick();
    tests_run++;
    if (pc !== 32'h3010 || redirect_pending !== 1'b1) begin
      tests_failed++; $display("FAIL stall_c3: got pc %h rp %b want 3010 rp 1", pc, redirect_pending);
    end
    stall = 1'b0; npc_sel = 2'b00;
    #1;
    tests_run++;
    if (npc !== 32'h3200) begin
      tests_failed++; $display("FAIL replay_npc: got %h want %h", npc, 32'h3200);
    end
    tick();
    tests_run++;
    if (pc !== 32'h3200 || redirect_pending !== 1'b0) begin
      tests_failed++; $display("FAIL replay: got pc %h rp %b want 3200 rp 0", pc, redirect_pending);
    end
    tests_run++;
    if (pc_n !== 32'h3014 || rp_n !== 1'b0) begin
      tests_failed++; $display("FAIL nohold_release: got pc %h rp %b want 3014 rp 0", pc_n, rp_n);
    end
  endtask

  task automatic test_exception;
    stall = 1'b1; npc_sel = 2'b01; br_target = 32'h3080;
    tick();
    tests_run++;
    if (redirect_pending !== 1'b1) begin
      tests_failed++; $display("FAIL exc_setup: got rp %b want 1", redirect_pending);
    end
    exc_req = 1'b1; eret = 1'b1; epc = 32'h3024;
    #1;
    tests_run++;
    if (npc !== 32'h4180) begin
      tests_failed++; $display("FAIL exc_npc: got %h want %h", npc, 32'h4180);
    end
    tick();
    tests_run++;
    if (pc !== 32'h4180 || redirect_pending !== 1'b0) begin
      tests_failed++; $display("FAIL exc_entry: got pc %h rp %b want 4180 rp 0", pc, redirect_pending);
    end
    exc_req = 1'b0; stall = 1'b0; npc_sel = 2'b00;
    tick();
    tests_run++;
    if (pc !== 32'h3024 || redirect_pending !== 1'b0) begin
      tests_failed++; $display("FAIL eret: got pc %h rp %b want 3024 rp 0", pc, redirect_pending);
    end
    eret = 1'b0;
  endtask

  task automatic test_boundary;
    npc_sel = 2'b11; j_target = 32'hFFFF_FFFC;
    tick();
    tests_run++;
    if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_pc4: got pc %h pc4 %h want fffffffc pc4 0", pc, pc4);
    end
    npc_sel = 2'b00;
    tick();
    tests_run++;
    if (pc !== 32'h0) begin
      tests_failed++; $display("FAIL wrap: got %h want 0", pc);
    end
    npc_sel = 2'b10; jr_target = 32'h3002;
    tick();
    tests_run++;
    if (pc !== 32'h3002 || pc_misaligned !== 1'b1) begin
      tests_failed++; $display("FAIL misaligned: got pc %h mis %b want 3002 mis 1", pc, pc_misaligned);
    end
    npc_sel = 2'b00;
    tick();
    tests_run++;
    if (pc !== 32'h3006 || pc_misaligned !== 1'b1) begin
      tests_failed++; $display("FAIL misaligned_next: got pc %h mis %b want 3006 mis 1", pc, pc_misaligned);
    end
  endtask

  task automatic test_reset_pending;
    stall = 1'b1; npc_sel = 2'b01; br_target = 32'h3080;
    tick();
    tests_run++;
    if (redirect_pending !== 1'b1) begin
      tests_failed++; $display("FAIL rstpend_setup: got rp %b want 1", redirect_pending);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (pc !== 32'h3000 || redirect_pending !== 1'b0) begin
      tests_failed++; $display("FAIL rstpend_reset: got pc %h rp %b want 3000 rp 0", pc, redirect_pending);
    end
    reset = 1'b0; stall = 1'b0; npc_sel = 2'b00;
    tick();
    tests_run++;
    if (pc !== 32'h3004 || redirect_pending !== 1'b0) begin
      tests_failed++; $display("FAIL rstpend_noreplay: got pc %h rp %b want 3004 rp 0", pc, redirect_pending);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_sel = 2'b00; exc_req = 1'b0; eret = 1'b0;
    br_target = '0; jr_target = '0; j_target = '0; epc = '0;
    #2;
    test_reset();
    test_select();
    test_stall_replay();
    test_exception();
    test_boundary();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
